// File: rtl/clock_time_pkg.sv
// Shared definitions for the time-of-day core: BCD digit layout, per-digit limits,
// digit indices and the bounded BCD increment used by both edit and run paths.
package clock_time_pkg;

    localparam int TIME_W = 20;
    localparam int SEL_W  = 6;

    localparam int S1_LSB = 0;
    localparam int S1_W   = 4;
    localparam int S2_LSB = 4;
    localparam int S2_W   = 3;
    localparam int M1_LSB = 7;
    localparam int M1_W   = 4;
    localparam int M2_LSB = 11;
    localparam int M2_W   = 3;
    localparam int H1_LSB = 14;
    localparam int H1_W   = 4;
    localparam int H2_LSB = 18;
    localparam int H2_W   = 2;

    typedef enum logic [2:0] {
        DIG_S1 = 3'd0,
        DIG_S2 = 3'd1,
        DIG_M1 = 3'd2,
        DIG_M2 = 3'd3,
        DIG_H1 = 3'd4,
        DIG_H2 = 3'd5
    } digit_e;

    localparam int DIG_LSB [SEL_W] = '{S1_LSB, S2_LSB, M1_LSB, M2_LSB, H1_LSB, H2_LSB};
    localparam int DIG_W   [SEL_W] = '{S1_W, S2_W, M1_W, M2_W, H1_W, H2_W};
    localparam logic [3:0] DIG_MAX [SEL_W] = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd2};
    // H1 limit once the hours tens digit reaches 2 (20..23)
    localparam logic [3:0] H1_MAX_H2 = 4'd3;

    localparam logic [SEL_W-1:0] SEL_FIRST = 6'b000001;

    typedef struct packed {
        logic              wrap;
        logic [TIME_W-1:0] t;
    } digit_step_t;

    function automatic logic [3:0] dig_max(input logic [TIME_W-1:0] t, input digit_e d);
        if (d == DIG_H1 && t[H2_LSB +: H2_W] == H2_W'(DIG_MAX[DIG_H2]))
            return H1_MAX_H2;
        return DIG_MAX[d];
    endfunction

    // Increment one digit field in place; at its limit the field clears and wrap is set.
    function automatic digit_step_t bcd_inc(input logic [TIME_W-1:0] t, input int lsb,
                                            input int w, input logic [3:0] lim);
        digit_step_t       r;
        logic [TIME_W-1:0] mask;
        logic [3:0]        d;
        mask = ((TIME_W'(1) << w) - TIME_W'(1)) << lsb;
        d    = 4'((t & mask) >> lsb);
        if (d >= lim) begin
            r.wrap = 1'b1;
            r.t    = t & ~mask;
        end else begin
            r.wrap = 1'b0;
            r.t    = t + (TIME_W'(1) << lsb);
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_time_tick.sv
// One-second prescaler: counts CLOCK_FREQUENCY cycles and flags the last one.
// While hold is high the count is parked at zero and no tick is produced.
module clock_time_tick #(
    parameter int CLOCK_FREQUENCY = 27_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCK_FREQUENCY - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = ~hold & (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (hold || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-of-day core: running 24h BCD clock with a button-driven digit editor.
// Define CLOCK_TIME_SEC_CLEAR_EN to zero the seconds whenever write mode is left.
module clock_time_ctrl
    import clock_time_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode_is_DT,
    input  logic              i_mode_wr_en,
    input  logic              i_time_left,
    input  logic              i_time_up,
    output logic [SEL_W-1:0]  o_time_sel,
    output logic [TIME_W-1:0] o_time_read_time
);

    logic              wr_en_p1, left_p1, up_p1;
    logic              wr_edge, left_edge, up_edge;
    logic              wr_mode_q, wr_mode_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              tick;
    logic              carry;
    digit_step_t       step;

    function automatic logic [TIME_W-1:0] exit_time(input logic [TIME_W-1:0] t);
`ifdef CLOCK_TIME_SEC_CLEAR_EN
        logic [TIME_W-1:0] r;
        r = t;
        r[S1_LSB +: S1_W] = '0;
        r[S2_LSB +: S2_W] = '0;
        return r;
`else
        return t;
`endif
    endfunction

    clock_time_tick #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) u_tick (
        .clk  (i_clk),
        .rst  (i_rst),
        .hold (wr_mode_q),
        .tick (tick)
    );

    assign wr_edge   = i_mode_wr_en & ~wr_en_p1;
    assign left_edge = i_time_left & ~left_p1;
    assign up_edge   = i_time_up & ~up_p1;

    always_comb begin
        wr_mode_d = wr_mode_q;
        sel_d     = sel_q;
        time_d    = time_q;
        step      = '0;
        carry     = 1'b0;

        if (i_mode_is_DT) begin
            wr_mode_d = 1'b0;
            sel_d     = '0;
            if (wr_mode_q)
                time_d = exit_time(time_q);
        end else if (wr_edge) begin
            // Mode toggle wins over any coincident cursor/increment edge
            wr_mode_d = ~wr_mode_q;
            sel_d     = wr_mode_q ? '0 : SEL_FIRST;
            if (wr_mode_q)
                time_d = exit_time(time_q);
        end else if (wr_mode_q) begin
            if (up_edge) begin
                for (int i = 0; i < SEL_W; i++) begin
                    if (sel_q[i]) begin
                        step   = bcd_inc(time_q, DIG_LSB[i], DIG_W[i], dig_max(time_q, digit_e'(i)));
                        time_d = step.t;
                    end
                end
                if (sel_q[DIG_H2] && time_d[H2_LSB +: H2_W] == H2_W'(DIG_MAX[DIG_H2])
                    && time_d[H1_LSB +: H1_W] > H1_MAX_H2)
                    time_d[H1_LSB +: H1_W] = '0;
            end
            if (left_edge)
                sel_d = {sel_q[SEL_W-2:0], sel_q[SEL_W-1]};
        end

        // Ticks only arrive outside write mode, so they never collide with edits
        if (!wr_mode_q && tick) begin
            carry = 1'b1;
            for (int i = 0; i < SEL_W; i++) begin
                if (carry) begin
                    step   = bcd_inc(time_d, DIG_LSB[i], DIG_W[i], dig_max(time_d, digit_e'(i)));
                    time_d = step.t;
                    carry  = step.wrap;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_en_p1  <= 1'b0;
            left_p1   <= 1'b0;
            up_p1     <= 1'b0;
            wr_mode_q <= 1'b0;
            sel_q     <= '0;
            time_q    <= '0;
        end else begin
            wr_en_p1  <= i_mode_wr_en;
            left_p1   <= i_time_left;
            up_p1     <= i_time_up;
            wr_mode_q <= wr_mode_d;
            sel_q     <= sel_d;
            time_q    <= time_d;
        end
    end

    assign o_time_sel       = sel_q;
    assign o_time_read_time = time_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl (CLOCK_FREQUENCY=2): a table of per-cycle button levels
// with expected outputs feeds a scoreboard queue, followed by hand-written reset sequences.
module tb_clock_time_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dt  = 1'b0;
    logic        wr  = 1'b0;
    logic        lf  = 1'b0;
    logic        up  = 1'b0;
    logic [5:0]  sel;
    logic [19:0] tm;

    clock_time_ctrl #(.CLOCK_FREQUENCY(2)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_mode_is_DT     (dt),
        .i_mode_wr_en     (wr),
        .i_time_left      (lf),
        .i_time_up        (up),
        .o_time_sel       (sel),
        .o_time_read_time (tm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dt, wr, lf, up;
        logic [5:0]  sel;
        logic [19:0] tm;
        string       name;
    } vec_t;

    typedef struct {
        logic [5:0]  sel;
        logic [19:0] tm;
        string       name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t cur_e;
    int   checks   = 0;
    int   failures = 0;

    // Expected editor state used while building the table
    int ed[6];
    int esel;
    bit wm;

    function automatic logic [19:0] pack(input int h2, input int h1, input int m2,
                                         input int m1, input int s2, input int s1);
        return {h2[1:0], h1[3:0], m2[2:0], m1[3:0], s2[2:0], s1[3:0]};
    endfunction

    function automatic logic [19:0] mtime();
        return pack(ed[5], ed[4], ed[3], ed[2], ed[1], ed[0]);
    endfunction

    function automatic logic [5:0] msel();
        return wm ? 6'(1 << esel) : 6'd0;
    endfunction

    function automatic int dmax(input int i);
        case (i)
            0, 2:    return 9;
            1, 3:    return 5;
            4:       return (ed[5] == 2) ? 3 : 9;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic w, input logic l, input logic u,
                       input logic [5:0] s, input logic [19:0] t, input string n);
        vec_t v;
        v.dt = d; v.wr = w; v.lf = l; v.up = u;
        v.sel = s; v.tm = t; v.name = n;
        tbl.push_back(v);
    endtask

    task automatic press(input logic w, input logic l, input logic u, input string n);
        add(1'b0, w, l, u, msel(), mtime(), n);
        add(1'b0, 1'b0, 1'b0, 1'b0, msel(), mtime(), {n, "_rel"});
    endtask

    task automatic ups(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            ed[esel] = (ed[esel] >= dmax(esel)) ? 0 : ed[esel] + 1;
            if (esel == 5 && ed[5] == 2 && ed[4] > 3)
                ed[4] = 0;
            press(1'b0, 1'b0, 1'b1, nm);
        end
    endtask

    task automatic lefts(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            esel = (esel + 1) % 6;
            press(1'b0, 1'b1, 1'b0, nm);
        end
    endtask

    task automatic spot(input string n, input logic [5:0] s, input logic [19:0] t);
        add(1'b0, 1'b0, 1'b0, 1'b0, s, t, n);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur_e = sb.pop_front();
            check({cur_e.name, "_sel"}, 32'(sel), 32'(cur_e.sel));
            check({cur_e.name, "_time"}, 32'(tm), 32'(cur_e.tm));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) ed[i] = 0;
        esel = 0;
        wm   = 1'b1;
        press(1'b1, 1'b0, 1'b0, "enter_wr");
        ups(5, "s1_up");
        spot("s1_eq5", 6'b000001, pack(0, 0, 0, 0, 0, 5));
        for (int d = 1; d < 6; d++) begin
            lefts(1, "cur_left");
            ups(2, "dig_up2");
        end
        spot("cur_at_h2", 6'b100000, pack(2, 2, 2, 2, 2, 5));
        lefts(1, "cur_wrap");
        spot("cur_wrapped", 6'b000001, pack(2, 2, 2, 2, 2, 5));
        ed[0] = 6;
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'b0, 1'b0, 1'b1, msel(), mtime(), "up_held");
        add(1'b0, 1'b0, 1'b0, 1'b0, msel(), mtime(), "up_held_rel");
        spot("held_plus1", 6'b000001, pack(2, 2, 2, 2, 2, 6));
        ups(3, "s1_to9");
        ups(1, "s1_wrap");
        spot("s1_wrap0", 6'b000001, pack(2, 2, 2, 2, 2, 0));
        lefts(1, "to_s2");
        ups(3, "s2_to5");
        ups(1, "s2_wrap");
        spot("s2_wrap_nocarry", 6'b000010, pack(2, 2, 2, 2, 0, 0));
        lefts(3, "to_h1");
        ups(1, "h1_to3");
        ups(1, "h1_wrap_h2eq2");
        spot("h1_wrap0", 6'b010000, pack(2, 0, 2, 2, 0, 0));
        lefts(1, "to_h2");
        ups(1, "h2_wrap");
        spot("h2_wrap0", 6'b100000, pack(0, 0, 2, 2, 0, 0));
        ups(1, "h2_to1");
        lefts(5, "to_h1_again");
        ups(7, "h1_to7");
        spot("h1_eq7", 6'b010000, pack(1, 7, 2, 2, 0, 0));
        lefts(1, "to_h2_clamp");
        ups(1, "h2_clamp");
        spot("h2_clamp_h1", 6'b100000, pack(2, 0, 2, 2, 0, 0));
        ed[5] = 0;
        esel  = 0;
        press(1'b0, 1'b1, 1'b1, "left_up_same");
        spot("left_up_same_chk", 6'b000001, pack(0, 0, 2, 2, 0, 0));
        ups(8, "pre_s1");
        lefts(1, "pre_l");
        ups(5, "pre_s2");
        lefts(1, "pre_l");
        ups(7, "pre_m1");
        lefts(1, "pre_l");
        ups(3, "pre_m2");
        lefts(1, "pre_l");
        ups(3, "pre_h1");
        lefts(1, "pre_l");
        ups(2, "pre_h2");
        spot("preset_235958", 6'b100000, pack(2, 3, 5, 9, 5, 8));
        wm = 1'b0;
        add(1'b0, 1'b1, 1'b1, 1'b1, 6'd0, pack(2, 3, 5, 9, 5, 8), "exit_wr_priority");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(2, 3, 5, 9, 5, 8), "run_c1");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(2, 3, 5, 9, 5, 9), "run_235959");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(2, 3, 5, 9, 5, 9), "run_c3");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 0), "run_midnight");
        add(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 0), "dt_wr");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 1), "dt_wr_rel");
        add(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 1), "dt_left");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 2), "dt_left_rel");
        add(1'b1, 1'b0, 1'b0, 1'b1, 6'd0, pack(0, 0, 0, 0, 0, 2), "dt_up");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 3), "dt_up_rel");
        add(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001, pack(0, 0, 0, 0, 0, 3), "reenter_wr");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001, pack(0, 0, 0, 0, 0, 3), "reenter_hold");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 3), "dt_force_exit");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 3), "exit_c1");
        add(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 4), "first_tick_after_exit");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 4), "run_c16");
        add(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, pack(0, 0, 0, 0, 0, 5), "run_c17");

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_time", 32'(tm), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            dt = tbl[i].dt;
            wr = tbl[i].wr;
            lf = tbl[i].lf;
            up = tbl[i].up;
            sb.push_back('{tbl[i].sel, tbl[i].tm, tbl[i].name});
            @(negedge clk);
        end
        dt = 1'b0; wr = 1'b0; lf = 1'b0; up = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);

        wr = 1'b1;
        @(posedge clk);
        #1;
        check("hand_enter_sel", 32'(sel), 32'b000001);
        check("hand_enter_time", 32'(tm), 32'(pack(0, 0, 0, 0, 0, 5)));
        @(negedge clk);
        wr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_mid_edit_sel", 32'(sel), 32'd0);
        check("reset_mid_edit_time", 32'(tm), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_no_tick", 32'(tm), 32'd0);
        @(posedge clk);
        #1;
        check("first_tick_after_reset", 32'(tm), 32'(pack(0, 0, 0, 0, 0, 1)));
        check("post_reset_sel", 32'(sel), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-of-day core for the alarm-clock design. It keeps a running 24-hour HH:MM:SS value in packed BCD, advancing once per second from a clock-cycle prescaler. It also provides a manual set mode in which a one-hot cursor selects a digit and button strobes increment it. It feeds the LCD digit formatter and the alarm comparator.

## Interface
- `CLOCK_FREQUENCY`, default 27_000_000: `i_clk` cycles per one-second tick; legal range ≥1.
- `i_clk` in 1: system clock, all logic on rising edge.
- `i_rst` in 1: reset, asynchronous and active-high.
- `i_mode_is_DT` in 1: 1 = display-time mode, buttons ignored; 0 = manual mode, buttons active.
- `i_mode_wr_en` in 1: button level; each rising edge toggles write (edit) mode.
- `i_time_left` in 1: button level; each rising edge moves the cursor one digit left.
- `i_time_up` in 1: button level; each rising edge increments the selected digit.
- `o_time_sel` out 6: one-hot cursor, bit0=S1 … bit5=H2; 0 when not editing.
- `o_time_read_time` out 20: packed BCD time, described in Operation.

## Operation
- Packing: S1[3:0] 0–9, S2[6:4] 0–5, M1[10:7] 0–9, M2[13:11] 0–5, H1[17:14] 0–9 (0–3 when H2=2), H2[19:18] 0–2.
- Buttons are internally rising-edge detected against a registered copy of the previous level. A held button produces one action.
- Button actions only occur when `i_mode_is_DT`=0.
- Write mode:
  - A wr_en edge with write mode off enters write mode with `o_time_sel`=000001.
  - A wr_en edge with write mode on exits write mode with `o_time_sel`=000000.
  - `i_mode_is_DT`=1 forces an exit from write mode.
- Cursor: a left edge rotates the one-hot left (000001→000010→…→100000→000001). Left edges outside write mode are ignored.
- Increment: an up edge adds 1 to the selected digit only.
  - At the digit's maximum the digit wraps to 0, with no carry into the neighbouring digit.
  - H1 maximum is 3 when H2=2, otherwise 9.
  - When H2 is incremented to 2 and H1>3, H1 becomes 0 in the same cycle.
- Running:
  - Outside write mode, the prescaler counts 0..CLOCK_FREQUENCY-1; on terminal count it issues one tick.
  - Each tick increments seconds with full BCD carry through M and H.
  - 23:59:59 wraps to 00:00:00.
- In write mode the prescaler is held at 0 and no ticks occur.
- Simultaneous left and up edges: the increment applies to the old cursor position and the cursor moves in the same edge.
- A wr_en edge in the same cycle as left or up: only the mode toggle is applied.

## Timing
- Reset values: time 00:00:00 (all 20 bits 0), `o_time_sel`=0, write mode off, prescaler 0, edge registers 0.
- All outputs are registered.
- A button edge sampled at clock edge n updates the outputs right after edge n (one-cycle response).
- First tick after reset or after leaving write mode: CLOCK_FREQUENCY cycles later.
- Reset mid-edit: immediate clear to reset values.

## Configuration
- `CLOCK_TIME_SEC_CLEAR_EN`:
  - Defined: leaving write mode clears S1 and S2 to 0, so the minute starts cleanly.
  - Undefined: seconds keep their edited value.

## Structure
- Package `clock_time_pkg` holds:
  - digit field LSB/width localparams;
  - per-digit max constants (9, 5, 9, 5, 9/3, 2);
  - the digit index enum S1..H2;
  - a BCD-increment-with-limit function.
- One sub-module, `clock_time_tick`: the CLOCK_FREQUENCY prescaler with a hold input and a single-cycle tick output.

## Test plan
- Set S1 by buttons: CLOCK_FREQUENCY=2, reset, wr_en pulse, 5 up pulses → sel=000001, S1=5, other digits 0, no ticks.
- Cursor movement and wrap: left ×5 with 2 ups each → sel steps 000010…100000, then a sixth left gives 000001. Result: S2=2, M1=2, M2=2, H1=2, H2=2.
- Per-digit overflow without carry:
  - S2 from 5, one up → S2=0, M1 unchanged.
  - S1 from 9 → 0.
  - H2 from 2 → 0.
  - H1 with H2=2 from 3 → 0.
- Clamp on H2 increment: H1=7, H2=1, up on H2 → H2=2, H1=0.
- Running carry: exit write mode at 23:59:58, CLOCK_FREQUENCY=2 → 23:59:59 after 2 cycles, then 00:00:00 after 4 cycles. Sel=0 throughout.
- Mode gating and hold:
  - With `i_mode_is_DT`=1, wr_en/left/up pulses leave sel=0 and the time unchanged apart from ticks.
  - An up held for 10 cycles in write mode gives exactly +1.
